modn_down_timer: RTL

Programmable mod-N down-counting timer, the counting-down counterpart of the team's mod-N up counter. It counts a loaded reload value down to zero. At zero it either reloads and continues (periodic mode) or stops (one-shot mode), and it raises a one-cycle terminal-count pulse each time zero is reached. It sits beside the up counter in the timing/divider layer and drives downstream event and strobe logic.

---
 rtl/modn_down_timer_pkg.sv | 17 +
 rtl/modn_down_timer_sat_counter.sv | 25 ++
 rtl/modn_down_timer.sv | 115 +++++++++++
 3 files changed

// File: rtl/modn_down_timer_pkg.sv
// Shared types and helpers for the mod-N timer family.
package modn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } modn_state_t;

    localparam int unsigned WRAP_W = 8;

    // Limit a requested count value to the legal range 0..n-1.
    function automatic int unsigned clamp_mod(input int unsigned val, input int unsigned n);
        return (val >= n) ? (n - 1) : val;
    endfunction

endpackage

// File: rtl/modn_down_timer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import modn_pkg::*;
#(
    parameter int unsigned W = WRAP_W
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/modn_down_timer.sv
// Programmable mod-N down-counting timer with periodic/one-shot modes,
// a one-cycle terminal-count pulse and a saturating reload counter.
module modn_down_timer
    import modn_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              start,
    input  logic              periodic,
    input  logic              en,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              busy,
    output logic [WRAP_W-1:0] wraps
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(N - 1);

    modn_state_t      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_tc, w_tc_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_wrap_inc;
    logic             w_wrap_clr;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_clamped = WIDTH'(clamp_mod(32'(load_val), N));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_out    <= TOP;
            r_reload <= TOP;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // tc defaults low so it is a single-cycle pulse whatever en does.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_mode_nxt   = r_mode;
        w_tc_nxt     = 1'b0;
        w_wrap_inc   = 1'b0;
        w_wrap_clr   = 1'b0;

        if (load) begin
            w_reload_nxt = w_load_clamped;
            w_out_nxt    = w_load_clamped;
            w_state_nxt  = IDLE;
            w_wrap_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_out_nxt   = r_reload;
                        w_mode_nxt  = periodic;
                        w_state_nxt = RUN;
                        w_tc_nxt    = (r_reload == '0);
                    end
                end
                RUN: begin
                    if (en) begin
                        if (r_out != '0) begin
                            w_out_nxt = r_out - WIDTH'(1);
                            w_tc_nxt  = (r_out == WIDTH'(1));
                        end else if (r_mode) begin
                            w_out_nxt  = r_reload;
                            w_wrap_inc = 1'b1;
                            w_tc_nxt   = (r_reload == '0);
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == RUN);
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wraps (
        .clk   (clk),
        .i_clr (reset | w_wrap_clr),
        .i_inc (w_wrap_inc),
        .o_cnt (wraps)
    );

    assign out  = r_out;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule
